// File: rtl/ring_frequency_meter.sv
// ============================================================================
// Module   : ring_frequency_meter
// Brief    : Counts ring-oscillator edges over a programmable window and flags
//            the ring as too fast (increment) or too slow (decrement).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ring_frequency_meter (
  input  logic       clk_frequency,
  input  logic       rst_frequency,
  input  logic       ring_clk,
  input  logic       init,
  input  logic [7:0] setperiod,
  input  logic [7:0] lo_limit,
  input  logic [7:0] hi_limit,
  output logic [7:0] count,
  output logic       valid,
  output logic       increment,
  output logic       decrement,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t      state;
  logic        s1, s2, s3;
  logic        edge_evt;
  logic        start;
  logic [7:0]  edge_cnt;
  logic [8:0]  win_cnt;
  logic [8:0]  win_len;
  logic [7:0]  period_q;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;

  assign edge_evt = s2 & ~s3;
  assign win_len  = (period_q == 8'd0) ? 9'd256 : {1'b0, period_q};
  // A new window opens from IDLE or directly out of REPORT.
  assign start    = init && ((state == IDLE) || (state == REPORT));

  always_ff @(posedge clk_frequency) begin
    if (rst_frequency) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      edge_cnt  <= 8'd0;
      win_cnt   <= 9'd0;
      period_q  <= 8'd0;
      lo_q      <= 8'd0;
      hi_q      <= 8'd0;
      count     <= 8'd0;
      valid     <= 1'b0;
      increment <= 1'b0;
      decrement <= 1'b0;
      busy      <= 1'b0;
    end else begin
      s1        <= ring_clk;
      s2        <= s1;
      s3        <= s2;
      valid     <= 1'b0;
      increment <= 1'b0;
      decrement <= 1'b0;

      case (state)
        IDLE: begin
          if (init) begin
            state <= MEASURE;
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (edge_evt) begin
            edge_cnt <= edge_cnt + 8'd1;
          end
          if (win_cnt == (win_len - 9'd1)) begin
            state   <= REPORT;
            win_cnt <= 9'd0;
          end else begin
            win_cnt <= win_cnt + 9'd1;
          end
        end
        REPORT: begin
          count <= edge_cnt;
          valid <= 1'b1;
          // Too fast takes precedence when inverted limits make both true.
          if (edge_cnt > hi_q) begin
            increment <= 1'b1;
          end else if (edge_cnt < lo_q) begin
            decrement <= 1'b1;
          end
          if (init) begin
            state <= MEASURE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (start) begin
        period_q <= setperiod;
        lo_q     <= lo_limit;
        hi_q     <= hi_limit;
        edge_cnt <= 8'd0;
        win_cnt  <= 9'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ring_frequency_meter.sv
// ============================================================================
// Module   : tb_ring_frequency_meter
// Brief    : Randomized self-checking bench for ring_frequency_meter.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_ring_frequency_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ring_clk = 1'b0;
  logic       init = 1'b0;
  logic [7:0] setperiod = 8'd0;
  logic [7:0] lo_limit = 8'd0;
  logic [7:0] hi_limit = 8'd0;
  logic [7:0] count;
  logic       valid;
  logic       increment;
  logic       decrement;
  logic       busy;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  edge_q[$];
  bit  ring_en = 1'b0;
  real ring_half = 50.0;

  ring_frequency_meter dut (
    .clk_frequency (clk),
    .rst_frequency (rst),
    .ring_clk      (ring_clk),
    .init          (init),
    .setperiod     (setperiod),
    .lo_limit      (lo_limit),
    .hi_limit      (hi_limit),
    .count         (count),
    .valid         (valid),
    .increment     (increment),
    .decrement     (decrement),
    .busy          (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  // Ring edges sit on a 0.3 ns phase so they never coincide with a clk edge.
  initial begin
    #3.3;
    forever begin
      if (ring_en) begin
        ring_clk = 1'b1;
        #(ring_half);
        ring_clk = 1'b0;
        #(ring_half);
      end else begin
        #1;
      end
    end
  end

  // Index of the clk edge that first samples each ring rising edge.
  always @(posedge ring_clk) edge_q.push_back(cyc + 1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ring(input int period_ns);
    ring_en   = (period_ns != 0);
    ring_half = (period_ns == 0) ? 50.0 : period_ns / 2.0;
  endtask

  // A ring edge sampled at edge k is seen as an event two edges later, which
  // must land on one of the N edges where the window (opened at edge e) counts.
  function automatic int exp_count(input int e, input int n);
    int c = 0;
    foreach (edge_q[i]) begin
      if (edge_q[i] >= e - 1 && edge_q[i] <= e + n - 2) c++;
    end
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (increment !== 1'b0) begin errors++; $display("FAIL reset_inc: got %0b expected 0", increment); end
    checks++; if (decrement !== 1'b0) begin errors++; $display("FAIL reset_dec: got %0b expected 0", decrement); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_windows(input string name, input int per, input int lo, input int hi,
                              input int ring_per, input int nwin);
    int n, e, exp;
    bit ei, ed, early;
    n = (per == 0) ? 256 : per;
    set_ring(ring_per);
    setperiod = per[7:0];
    lo_limit  = lo[7:0];
    hi_limit  = hi[7:0];
    init      = 1'b1;
    e         = cyc + 1;
    for (int w = 0; w < nwin; w++) begin
      early = 1'b0;
      while (cyc < e + n + 1) begin
        tick();
        if (cyc == e) begin
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %0b expected 1", name, busy); end
        end
        if (cyc == e + n / 2) begin
          setperiod = 8'($urandom);
          lo_limit  = 8'($urandom);
          hi_limit  = 8'($urandom);
        end
        if (cyc == e + n) begin
          setperiod = per[7:0];
          lo_limit  = lo[7:0];
          hi_limit  = hi[7:0];
          if (w == nwin - 1) init = 1'b0;
        end
        if (cyc < e + n + 1 && valid !== 1'b0) early = 1'b1;
      end
      exp = exp_count(e, n);
      ei  = (exp > hi);
      ed  = !ei && (exp < lo);
      checks++; if (early) begin errors++; $display("FAIL %s early_valid: got early pulse expected none in window %0d", name, w); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL %s valid: got %0b expected 1 in window %0d", name, valid, w); end
      checks++; if (count !== exp[7:0]) begin errors++; $display("FAIL %s count: got %0d expected %0d in window %0d", name, count, exp, w); end
      checks++; if (increment !== ei) begin errors++; $display("FAIL %s increment: got %0b expected %0b", name, increment, ei); end
      checks++; if (decrement !== ed) begin errors++; $display("FAIL %s decrement: got %0b expected %0b", name, decrement, ed); end
      e = e + n + 1;
    end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL %s valid_pulse: got %0b expected 0", name, valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s end_busy: got %0b expected 0", name, busy); end
  endtask

  task automatic test_init_drop();
    int e, exp;
    bit late;
    set_ring(100);
    setperiod = 8'd100;
    lo_limit  = 8'd15;
    hi_limit  = 8'd25;
    init      = 1'b1;
    e         = cyc + 1;
    while (cyc < e + 101) begin
      tick();
      if (cyc == e + 39) init = 1'b0;
    end
    exp = exp_count(e, 100);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL drop valid: got %0b expected 1", valid); end
    checks++; if (count !== exp[7:0]) begin errors++; $display("FAIL drop count: got %0d expected %0d", count, exp); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop busy: got %0b expected 0", busy); end
    late = 1'b0;
    repeat (150) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) late = 1'b1;
    end
    checks++; if (late) begin errors++; $display("FAIL drop idle: got activity expected none"); end
  endtask

  task automatic test_reset_mid();
    int e, e2, exp;
    bit early;
    set_ring(100);
    setperiod = 8'd100;
    lo_limit  = 8'd15;
    hi_limit  = 8'd25;
    init      = 1'b1;
    e         = cyc + 1;
    while (cyc < e + 59) begin
      tick();
      if (cyc == e + 20) set_ring(0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid valid: got %0b expected 0", valid); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL rstmid count: got %0d expected 0", count); end
    checks++; if (increment !== 1'b0 || decrement !== 1'b0) begin errors++; $display("FAIL rstmid flags: got %0b%0b expected 00", increment, decrement); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %0b expected 0", busy); end
    e2 = cyc + 1;
    early = 1'b0;
    while (cyc < e2 + 101) begin
      tick();
      if (cyc == e2) set_ring(100);
      if (cyc == e2 + 100) init = 1'b0;
      if (cyc < e2 + 101 && valid !== 1'b0) early = 1'b1;
    end
    exp = exp_count(e2, 100);
    checks++; if (early) begin errors++; $display("FAIL rstmid early_valid: got pulse expected none"); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rstmid valid_after: got %0b expected 1", valid); end
    checks++; if (count !== exp[7:0]) begin errors++; $display("FAIL rstmid count_after: got %0d expected %0d", count, exp); end
    tick();
  endtask

  task automatic test_random();
    int per, rp, lo, hi;
    for (int i = 0; i < 4; i++) begin
      per = $urandom_range(0, 255);
      rp  = $urandom_range(44, 400);
      lo  = $urandom_range(0, 40);
      hi  = $urandom_range(0, 60);
      test_windows("random", per, lo, hi, rp, 2);
    end
  endtask

  initial begin
    test_reset();
    test_windows("nominal", 100, 15, 25, 100, 3);
    test_windows("fast", 100, 15, 25, 40 + 4, 1);
    test_windows("fast40", 100, 15, 25, 44, 2);
    test_windows("zero_period", 0, 1, 255, 0, 1);
    test_init_drop();
    test_reset_mid();
    test_windows("priority", 100, 200, 10, 100, 1);
    test_windows("short", 1, 0, 0, 60, 2);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
